// File: rtl/igniter_move_planner_if.sv
// Request and igniter-command bundle for igniter_move_planner.
// The master side issues ignition requests and watches the igniter command stream.
// The slave side is the planner.
interface igniter_move_planner_if;
  logic       req_valid;
  logic [2:0] req_target;
  logic       req_ready;
  logic       enable_move;
  logic [3:0] delta;
  logic [2:0] pos_mirror;
  logic       ignite;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_target,
    input  req_ready, enable_move, delta, pos_mirror, ignite, busy, done
  );

  modport slave (
    input  req_valid, req_target,
    output req_ready, enable_move, delta, pos_mirror, ignite, busy, done
  );
endinterface

// File: rtl/igniter_move_planner.sv
// igniter_move_planner: takes a target candle position and steps a forward-only,
// modulo-8 igniter toward it in chunks of at most MAX_STEP.
// It then holds ignite for DWELL_CYCLES cycles and pulses done.
// Define IGNITER_REQ_FIFO_EN to buffer up to four requests ahead of the FSM.
// In that build req_ready follows FIFO space instead of the IDLE state.
module igniter_move_planner #(
  parameter int MAX_STEP     = 3,
  parameter int DWELL_CYCLES = 16
) (
  input logic                  sys_clk,
  input logic                  clr,
  igniter_move_planner_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PLAN, MOVE, DWELL, DONE} state_t;

  localparam logic [2:0]  MAX_STEP_3 = 3'(MAX_STEP);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  target, target_next;
  logic [2:0]  pos, pos_next;
  logic [2:0]  dist_rem, dist_rem_next;
  logic [15:0] dwell_cnt, dwell_cnt_next;
  logic        enable_move, enable_move_next;
  logic [3:0]  delta, delta_next;
  logic        ignite, ignite_next;
  logic        busy, busy_next;
  logic        done, done_next;
  logic [2:0]  plan_dist;
  logic [2:0]  step;
  logic        ready;
  logic        have_req;
  logic [2:0]  head_target;
  logic        take_req;

`ifdef IGNITER_REQ_FIFO_EN
  logic [2:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_count;
  logic       push;

  assign ready       = (fifo_count != 3'd4) && !clr;
  assign push        = bus.req_valid && ready;
  assign have_req    = (fifo_count != 3'd0);
  assign head_target = fifo_mem[rd_ptr];

  // Request FIFO: pushes on an accepted handshake, pops when IDLE takes the head.
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.req_target;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (take_req) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      fifo_count <= fifo_count + {2'b00, push} - {2'b00, take_req};
    end
  end
`else
  assign ready       = (state == IDLE) && !clr;
  assign have_req    = bus.req_valid && ready;
  assign head_target = bus.req_target;
`endif

  assign take_req = (state == IDLE) && have_req;

  assign bus.req_ready   = ready;
  assign bus.enable_move = enable_move;
  assign bus.delta       = delta;
  assign bus.pos_mirror  = pos;
  assign bus.ignite      = ignite;
  assign bus.busy        = busy;
  assign bus.done        = done;

  // Next-state and next-output logic; PLAN and MOVE share the step decision.
  // In PLAN the distance is fresh; in MOVE it is the remaining distance.
  always_comb begin
    state_next       = state;
    target_next      = target;
    pos_next         = pos;
    dist_rem_next    = dist_rem;
    dwell_cnt_next   = dwell_cnt;
    enable_move_next = 1'b0;
    delta_next       = 4'd0;
    ignite_next      = 1'b0;
    done_next        = 1'b0;
    plan_dist        = (state == PLAN) ? (target - pos) : dist_rem;
    step             = (plan_dist > MAX_STEP_3) ? MAX_STEP_3 : plan_dist;

    case (state)
      IDLE: begin
        if (take_req) begin
          target_next = head_target;
          state_next  = PLAN;
        end
      end
      PLAN, MOVE: begin
        if (plan_dist == 3'd0) begin
          state_next     = DWELL;
          dist_rem_next  = 3'd0;
          dwell_cnt_next = DWELL_LAST;
          ignite_next    = 1'b1;
        end else begin
          state_next       = MOVE;
          enable_move_next = 1'b1;
          delta_next       = {1'b0, step};
          pos_next         = pos + step;
          dist_rem_next    = plan_dist - step;
        end
      end
      DWELL: begin
        if (dwell_cnt == 16'd0) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          dwell_cnt_next = dwell_cnt - 16'd1;
          ignite_next    = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and registered outputs; clr overrides everything, including mid-move.
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      state       <= IDLE;
      target      <= 3'd0;
      pos         <= 3'd0;
      dist_rem    <= 3'd0;
      dwell_cnt   <= 16'd0;
      enable_move <= 1'b0;
      delta       <= 4'd0;
      ignite      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      target      <= target_next;
      pos         <= pos_next;
      dist_rem    <= dist_rem_next;
      dwell_cnt   <= dwell_cnt_next;
      enable_move <= enable_move_next;
      delta       <= delta_next;
      ignite      <= ignite_next;
      busy        <= busy_next;
      done        <= done_next;
    end
  end
endmodule

// File: tb/tb_igniter_move_planner.sv
// Self-checking bench for igniter_move_planner (MAX_STEP=3, DWELL_CYCLES=4).
// Expected per-cycle traces come from a step-list model of forward modulo-8 motion.
// Also exercises the IGNITER_REQ_FIFO_EN build when that macro is defined.
module tb_igniter_move_planner;
  localparam int MAX_STEP = 3;
  localparam int DWELL    = 4;
`ifdef IGNITER_REQ_FIFO_EN
  localparam int LAT  = 2;
  localparam bit FIFO = 1'b1;
`else
  localparam int LAT  = 1;
  localparam bit FIFO = 1'b0;
`endif

  typedef struct {
    logic       en;
    logic [3:0] delta;
    logic [2:0] pos;
    logic       ign;
    logic       done;
    logic       busy;
  } snap_t;

  logic  sys_clk = 1'b0;
  logic  clr;
  int    errors = 0;
  int    checks = 0;
  int    model_pos = 0;
  snap_t exp_q[$];

  igniter_move_planner_if bus ();

  igniter_move_planner #(.MAX_STEP(MAX_STEP), .DWELL_CYCLES(DWELL)) dut (
    .sys_clk(sys_clk),
    .clr    (clr),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_snap(input string tag, input snap_t e);
    check_output({tag, ".enable_move"}, bus.enable_move, e.en);
    check_output({tag, ".delta"},       bus.delta,       e.delta);
    check_output({tag, ".pos_mirror"},  bus.pos_mirror,  e.pos);
    check_output({tag, ".ignite"},      bus.ignite,      e.ign);
    check_output({tag, ".done"},        bus.done,        e.done);
    check_output({tag, ".busy"},        bus.busy,        e.busy);
  endtask

  // Expected cycle-by-cycle trace following the accept edge, from model_pos to target.
  function automatic void build_trace(input int target);
    int p;
    int rem;
    int s;
    exp_q.delete();
    p   = model_pos;
    rem = (target - p) & 7;
    for (int i = 1; i <= LAT; i++)
      exp_q.push_back('{1'b0, 4'd0, 3'(p), 1'b0, 1'b0, 1'(i == LAT)});
    while (rem > 0) begin
      s   = (rem < MAX_STEP) ? rem : MAX_STEP;
      p   = (p + s) % 8;
      rem = rem - s;
      exp_q.push_back('{1'b1, 4'(s), 3'(p), 1'b0, 1'b0, 1'b1});
    end
    for (int i = 0; i < DWELL; i++)
      exp_q.push_back('{1'b0, 4'd0, 3'(p), 1'b1, 1'b0, 1'b1});
    exp_q.push_back('{1'b0, 4'd0, 3'(p), 1'b0, 1'b1, 1'b1});
    exp_q.push_back('{1'b0, 4'd0, 3'(p), 1'b0, 1'b0, 1'b0});
    model_pos = p;
  endfunction

  // Present one request, wait (bounded) for acceptance, then compare the full trace.
  task automatic apply_stimulus(input int target, input bit hold, input string name);
    int waited;
    waited = 0;
    build_trace(target);
    bus.req_valid  = 1'b1;
    bus.req_target = 3'(target);
    while (!bus.req_ready && waited < 50) begin
      tick();
      waited++;
    end
    check_output({name, ".accept_ready"}, bus.req_ready, 1'b1);
    tick();
    if (!hold) bus.req_valid = 1'b0;
    foreach (exp_q[i]) begin
      check_snap($sformatf("%s.c%0d", name, i + 1), exp_q[i]);
      if (hold) check_output($sformatf("%s.c%0d.req_ready", name, i + 1), bus.req_ready, !exp_q[i].busy);
      if (i == exp_q.size() - 1) bus.req_valid = 1'b0;
      else tick();
    end
    if (hold) begin
      tick();
      check_output({name, ".accepted_once"}, bus.busy, 1'b0);
    end
  endtask

  initial begin
    int t;
    int dones;
    int served[$];
    string name;

    $display("[TB] igniter_move_planner bench start (LAT=%0d)", LAT);
    clr            = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_target = 3'd3;
    tick();
    tick();
    check_snap("reset", '{1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    check_output("reset.req_ready", bus.req_ready, 1'b0);
    bus.req_valid = 1'b0;
    clr           = 1'b0;
    tick();
    check_output("post_reset.req_ready", bus.req_ready, 1'b1);

    apply_stimulus(5, 1'b0, "to5");
    apply_stimulus(2, !FIFO, "wrap5to2");
    apply_stimulus(2, 1'b0, "same_pos");

    // Seven-step request interrupted by clr during its second MOVE cycle.
    t              = (model_pos + 7) % 8;
    bus.req_valid  = 1'b1;
    bus.req_target = 3'(t);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < LAT + 1; i++) tick();
    check_output("clr_mid.second_move", bus.enable_move, 1'b1);
    check_output("clr_mid.second_delta", bus.delta, 4'd3);
    clr = 1'b1;
    tick();
    check_snap("clr_mid.after", '{1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    check_output("clr_mid.req_ready", bus.req_ready, 1'b0);
    clr       = 1'b0;
    model_pos = 0;
    tick();
    check_output("clr_mid.idle_again", bus.busy, 1'b0);

`ifdef IGNITER_REQ_FIFO_EN
    // Dummy request occupies the FSM; targets 1..4 fill the FIFO and 5 is refused.
    t             = (model_pos + 4) % 8;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.req_target = (i == 0) ? 3'(t) : 3'(i);
      if (i > 0) check_output($sformatf("fifo.push%0d.req_ready", i), bus.req_ready, 1'(i < 5));
      tick();
    end
    bus.req_valid = 1'b0;
    dones = 0;
    for (int c = 0; c < 300; c++) begin
      if (bus.done) begin
        served.push_back(int'(bus.pos_mirror));
        dones++;
      end
      tick();
    end
    check_output("fifo.done_count", 16'(dones), 16'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < served.size())
        check_output($sformatf("fifo.order%0d", i), 16'(served[i]), (i == 0) ? 16'(t) : 16'(i));
    end
    model_pos = 4;
`endif

    for (int n = 0; n < 24; n++) begin
      t    = int'($urandom_range(0, 7));
      name = $sformatf("rand%0d", n);
      apply_stimulus(t, !FIFO && $urandom_range(0, 1) == 1, name);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/igniter_move_planner.md
IGNITER_MOVE_PLANNER -- requirements
Module: igniter_move_planner

Interface
REQ-001 The block SHALL have parameter MAX_STEP, default 3, the largest per-move position step, legal range 1..7.
REQ-002 The block SHALL have parameter DWELL_CYCLES, default 16, the ignite hold length in cycles, legal range 1..65535.
REQ-003 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  ignition request present.
REQ-006 req_target  input  3  requested candle position, 0..7.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-008 enable_move  output  1  one-cycle step command to the downstream igniter.
REQ-009 delta  output  4  step size for the igniter; bit 3 always 0.
REQ-010 pos_mirror  output  3  tracked igniter position after the last issued step.
REQ-011 ignite  output  1  high while the dwell is active.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a request completes.

Function
REQ-014 The FSM SHALL have states IDLE, PLAN, MOVE, DWELL and DONE; all outputs SHALL be registered.
REQ-015 IDLE SHALL take a request (accepted handshake, or FIFO head when the macro is enabled), latch the target and enter PLAN next cycle.
REQ-016 PLAN SHALL last 1 cycle: dist_rem = (target - pos_mirror) mod 8, 3-bit wrap; dist_rem==0 -> DWELL, else -> MOVE.
REQ-017 Each MOVE cycle SHALL:
- assert enable_move=1 with delta={1'b0, step}, step=min(dist_rem, MAX_STEP);
- update pos_mirror=(pos_mirror+step) mod 8 and dist_rem-=step;
- go to DWELL when the new dist_rem==0.
REQ-018 Motion SHALL be forward only, modulo 8; moves are back-to-back with no gap cycles.
REQ-019 Outside MOVE, enable_move SHALL be 0 and delta SHALL be 0.
REQ-020 DWELL SHALL hold ignite=1 for exactly DWELL_CYCLES cycles using a 16-bit counter, then enter DONE.
REQ-021 DONE SHALL pulse done=1 for 1 cycle and return to IDLE.
REQ-022 Latency from accept at edge T (no FIFO) SHALL be: PLAN at T+1, first enable_move at T+2.
REQ-023 pos_mirror SHALL match the igniter's position, given a shared reset and one step per enable_move.

Reset
REQ-024 When clr=1 at a rising edge, the block SHALL take the following values, overriding any other activity, including mid-MOVE or mid-DWELL:
- state=IDLE, pos_mirror=0, dist_rem=0, dwell counter=0;
- enable_move=0, delta=0, ignite=0, busy=0, done=0;
- FIFO emptied, in-flight request discarded.
REQ-025 req_ready SHALL be 0 while clr=1.

Configuration
REQ-026 The macro IGNITER_REQ_FIFO_EN SHALL compile in a 4-entry request FIFO.
- Defined: req_ready=!full, independent of FSM state; IDLE pops the head, so accept at T gives PLAN at T+2; requests are served in order; a push while full is not accepted.
- Undefined: no FIFO; req_ready=1 only in IDLE, giving single outstanding request semantics.

Verification
REQ-027 Reset, MAX_STEP=3, DWELL=4, target 5 -> enable_move with delta 3 then delta 2; pos_mirror 3 then 5; ignite for 4 cycles; one done pulse.
REQ-028 From pos 5, request target 2 -> dist 5; delta 3 (pos 0, wrap) then delta 2 (pos 2).
REQ-029 Target equal to pos_mirror -> no enable_move; PLAN goes directly to DWELL.
REQ-030 clr asserted in the 2nd MOVE cycle of a 7-step request -> next cycle all outputs 0, pos_mirror 0, state IDLE.
REQ-031 With IGNITER_REQ_FIFO_EN, 5 back-to-back requests (targets 1,2,3,4,5) while busy -> first 4 accepted, req_ready=0 for the 5th; targets served in order 1,2,3,4.
REQ-032 Without the macro, req_valid held during busy -> req_ready=0 until IDLE; accepted exactly once.
